// File: rtl/jk_latch_exerciser.sv
// jk_latch_exerciser: self-checking stimulus sequencer that drives a JK latch and scores its q/qn outputs
module jk_latch_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_i,
  input  logic       qn_i,
  output logic       enable_o,
  output logic       j_o,
  output logic       k_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [2:0] vec_idx
);
  typedef enum logic [2:0] {IDLE, INIT, APPLY, CHECK, DONE} state_t;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);
  state_t state;
  logic [3:0] cnt, pass_cnt;
  logic model_q, model_valid;
  logic hold, forced, exp_q, checked, miss;
  logic [7:0] err_next;
  // vec_idx mirrors the driven vector, so the model is evaluated from it directly
  always_comb begin
    hold = !vec_idx[2] || vec_idx[1:0] == 2'b00;
    forced = !hold && vec_idx[1] != vec_idx[0];
    exp_q = hold ? model_q : vec_idx[1];
    checked = hold ? model_valid : forced;
    miss = checked && (q_i != exp_q || qn_i != !exp_q);
    err_next = err_count + 8'(miss && err_count != 8'hff);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pass_cnt <= '0;
      model_q <= 1'b0;
      model_valid <= 1'b0;
      {enable_o, j_o, k_o} <= 3'b000;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      vec_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= INIT;
          busy <= 1'b1;
          pass <= 1'b0;
          err_count <= '0;
          pass_cnt <= '0;
          cnt <= '0;
          vec_idx <= '0;
          {enable_o, j_o, k_o} <= 3'b101;
        end
        INIT: begin
          model_q <= 1'b0;
          model_valid <= 1'b1;
          cnt <= cnt == SETTLE_LAST ? 4'd0 : cnt + 4'd1;
          if (cnt == SETTLE_LAST) begin
            state <= APPLY;
            {enable_o, j_o, k_o} <= 3'b000;
          end
        end
        APPLY: begin
          cnt <= cnt == SETTLE_LAST ? 4'd0 : cnt + 4'd1;
          if (cnt == SETTLE_LAST) state <= CHECK;
        end
        CHECK: begin
          err_count <= err_next;
          model_q <= exp_q;
          model_valid <= checked;
          if (vec_idx != 3'd7) begin
            state <= APPLY;
            vec_idx <= vec_idx + 3'd1;
            {enable_o, j_o, k_o} <= vec_idx + 3'd1;
          end else if (pass_cnt != PASS_LAST) begin
            state <= INIT;
            pass_cnt <= pass_cnt + 4'd1;
            vec_idx <= '0;
            {enable_o, j_o, k_o} <= 3'b101;
          end else begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_next == 8'd0;
            {enable_o, j_o, k_o} <= 3'b000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
